// File: rtl/mem_port_arbiter_if.sv
// Memory-port bundle: request (addr/rmask/wmask/wdata) and response (rdata/resp).
// master drives the request side, slave drives rdata/resp.
interface mem_port_arbiter_if;
   logic [31:0] addr;
   logic [3:0]  rmask;
   logic [3:0]  wmask;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        resp;

   modport master (
      output addr, rmask, wmask, wdata,
      input  rdata, resp
   );

   modport slave (
      input  addr, rmask, wmask, wdata,
      output rdata, resp
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D) requesters.
// Ports: clk, rst (async, active-high); fetch/lsu slave ports; mem master port;
// err = sticky timeout flag. Optional ARB_ROUND_ROBIN_EN: alternate on contention.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   fetch,
   mem_port_arbiter_if.slave   lsu,
   mem_port_arbiter_if.master  mem,
   output logic                err
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } state_t;

   state_t      state;
   logic [31:0] addr_q;
   logic [3:0]  rmask_q;
   logic [3:0]  wmask_q;
   logic [31:0] wdata_q;
   logic [CW-1:0] cnt;

   logic i_pend;
   logic d_pend;
   logic pick_d;

   assign i_pend = |fetch.rmask;
   assign d_pend = (|lsu.rmask) | (|lsu.wmask);

`ifdef ARB_ROUND_ROBIN_EN
   // last_d = 1 when the most recent grant went to D
   logic last_d;
   assign pick_d = d_pend & (~i_pend | ~last_d);
`else
   assign pick_d = d_pend;
`endif

   assign mem.addr  = addr_q;
   assign mem.rmask = rmask_q;
   assign mem.wmask = wmask_q;
   assign mem.wdata = wdata_q;

   assign fetch.rdata = mem.rdata;
   assign lsu.rdata   = mem.rdata;

   // Completion is routed combinationally to the current owner only
   assign fetch.resp = (state == BUSY_I) & mem.resp;
   assign lsu.resp   = (state == BUSY_D) & mem.resp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         rmask_q <= '0;
         wmask_q <= '0;
         wdata_q <= '0;
         cnt     <= '0;
         err     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_d) begin
                  state   <= BUSY_D;
                  addr_q  <= lsu.addr;
                  rmask_q <= lsu.rmask;
                  wmask_q <= lsu.wmask;
                  wdata_q <= lsu.wdata;
                  cnt     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                  last_d  <= 1'b1;
`endif
               end else if (i_pend) begin
                  state   <= BUSY_I;
                  addr_q  <= fetch.addr;
                  rmask_q <= fetch.rmask;
                  wmask_q <= '0;
                  wdata_q <= '0;
                  cnt     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                  last_d  <= 1'b0;
`endif
               end
            end
            BUSY_I, BUSY_D: begin
               if (mem.resp) begin
                  state   <= IDLE;
                  rmask_q <= '0;
                  wmask_q <= '0;
               end else if (TIMEOUT_CYCLES != 0) begin
                  // Saturating count; err flags but never aborts
                  if (cnt != TMAX) begin
                     cnt <= cnt + 1'b1;
                     if (cnt + 1'b1 == TMAX)
                        err <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               rmask_q <= '0;
               wmask_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected grants,
// responder model for the downstream port, immediate-assertion checks.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        d;
      logic [31:0] addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   logic clk;
   logic rst;
   logic err;

   int vectors;
   int miscompares;

   txn_t sb[$];

   mem_port_arbiter_if fb ();
   mem_port_arbiter_if lb ();
   mem_port_arbiter_if mb ();

   mem_port_arbiter #(
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .fetch (fb),
      .lsu   (lb),
      .mem   (mb),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req_i(input logic [31:0] a, input logic [3:0] rm,
                        input logic [31:0] rd);
      txn_t t;
      fb.addr  = a;
      fb.rmask = rm;
      t = '{d: 1'b0, addr: a, rmask: rm, wmask: 4'h0, wdata: 32'h0, rdata: rd};
      sb.push_back(t);
   endtask

   task automatic req_d(input logic [31:0] a, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd,
                        input logic [31:0] rd);
      txn_t t;
      lb.addr  = a;
      lb.rmask = rm;
      lb.wmask = wm;
      lb.wdata = wd;
      t = '{d: 1'b1, addr: a, rmask: rm, wmask: wm, wdata: wd, rdata: rd};
      sb.push_back(t);
   endtask

   // Request driven just after an edge: first negedge is still IDLE,
   // the second shows the grant, so a one-cycle latency gives k == 2.
   task automatic wait_grant(output txn_t t);
      int k;
      k = 0;
      t = '0;
      do begin
         @(negedge clk);
         k++;
      end while (!((|mb.rmask) || (|mb.wmask)) && k < 20);
      chk("grant_wait", k, 2);
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         t = sb.pop_front();
         chk("grant_addr", mb.addr, t.addr);
         chk("grant_rmask", {28'h0, mb.rmask}, {28'h0, t.rmask});
         chk("grant_wmask", {28'h0, mb.wmask}, {28'h0, t.wmask});
         if (t.wmask != 4'h0)
            chk("grant_wdata", mb.wdata, t.wdata);
      end
   endtask

   task automatic serve(input int lat);
      txn_t t;
      wait_grant(t);
      repeat (lat) @(negedge clk);
      chk("held_addr", mb.addr, t.addr);
      chk("held_rmask", {28'h0, mb.rmask}, {28'h0, t.rmask});
      @(posedge clk);
      #1;
      mb.rdata = t.rdata;
      mb.resp  = 1'b1;
      @(negedge clk);
      if (t.d) begin
         chk("d_resp", {31'h0, lb.resp}, 32'h1);
         chk("i_resp_quiet", {31'h0, fb.resp}, 32'h0);
         chk("d_rdata", lb.rdata, t.rdata);
      end else begin
         chk("i_resp", {31'h0, fb.resp}, 32'h1);
         chk("d_resp_quiet", {31'h0, lb.resp}, 32'h0);
         chk("i_rdata", fb.rdata, t.rdata);
      end
      @(posedge clk);
      #1;
      mb.resp  = 1'b0;
      mb.rdata = 32'h0;
      if (t.d) begin
         lb.rmask = 4'h0;
         lb.wmask = 4'h0;
      end else begin
         fb.rmask = 4'h0;
      end
   endtask

   initial begin
      txn_t t;
      vectors     = 0;
      miscompares = 0;
      rst      = 1'b1;
      fb.addr  = 32'h0;
      fb.rmask = 4'h0;
      fb.wmask = 4'h0;
      fb.wdata = 32'h0;
      lb.addr  = 32'h0;
      lb.rmask = 4'h0;
      lb.wmask = 4'h0;
      lb.wdata = 32'h0;
      mb.rdata = 32'h0;
      mb.resp  = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_addr", mb.addr, 32'h0);
      chk("rst_rmask", {28'h0, mb.rmask}, 32'h0);
      chk("rst_wmask", {28'h0, mb.wmask}, 32'h0);
      chk("rst_wdata", mb.wdata, 32'h0);
      chk("rst_i_resp", {31'h0, fb.resp}, 32'h0);
      chk("rst_d_resp", {31'h0, lb.resp}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset in the middle of a D transaction
      req_d(32'h1eceb200, 4'hF, 4'h0, 32'h0, 32'h0);
      wait_grant(t);
      @(posedge clk);
      #1;
      rst      = 1'b1;
      lb.rmask = 4'h0;
      @(negedge clk);
      chk("midrst_rmask", {28'h0, mb.rmask}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      mb.resp  = 1'b1;
      mb.rdata = 32'h55aa55aa;
      @(negedge clk);
      chk("late_d_resp", {31'h0, lb.resp}, 32'h0);
      chk("late_i_resp", {31'h0, fb.resp}, 32'h0);
      chk("late_rmask", {28'h0, mb.rmask}, 32'h0);
      chk("late_err", {31'h0, err}, 32'h0);
      @(posedge clk);
      #1;
      mb.resp  = 1'b0;
      mb.rdata = 32'h0;
      @(negedge clk);
      chk("idle_rmask", {28'h0, mb.rmask}, 32'h0);
      chk("idle_wmask", {28'h0, mb.wmask}, 32'h0);
      @(posedge clk);
      #1;

      // Lone fetch
      req_i(32'h1eceb000, 4'hF, 32'h00000013);
      serve(1);

      // Simultaneous store and fetch: D first, then I after one IDLE cycle
      req_d(32'h1eceb100, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0);
      req_i(32'h1eceb004, 4'hF, 32'h00100093);
      serve(2);
      serve(0);

      // Back-to-back loads, masks unmodified
      req_d(32'h1eceb201, 4'h1, 4'h0, 32'h0, 32'h000000AB);
      serve(1);
      req_d(32'h1eceb202, 4'h3, 4'h0, 32'h0, 32'h0000BEEF);
      serve(0);

      // Contention after a D grant
`ifdef ARB_ROUND_ROBIN_EN
      req_i(32'h1eceb008, 4'hF, 32'h00208113);
      req_d(32'h1eceb300, 4'hF, 4'h0, 32'h0, 32'h12345678);
`else
      req_d(32'h1eceb300, 4'hF, 4'h0, 32'h0, 32'h12345678);
      req_i(32'h1eceb008, 4'hF, 32'h00208113);
`endif
      serve(1);
      serve(1);
      chk("err_clean", {31'h0, err}, 32'h0);

      // Timeout with withheld completion
      req_d(32'h1eceb400, 4'hF, 4'h0, 32'h0, 32'hCAFE0001);
      wait_grant(t);
      repeat (7) @(negedge clk);
      chk("err_before", {31'h0, err}, 32'h0);
      @(negedge clk);
      chk("err_rise", {31'h0, err}, 32'h1);
      @(posedge clk);
      #1;
      mb.resp  = 1'b1;
      mb.rdata = t.rdata;
      @(negedge clk);
      chk("to_d_resp", {31'h0, lb.resp}, 32'h1);
      chk("to_d_rdata", lb.rdata, 32'hCAFE0001);
      @(posedge clk);
      #1;
      mb.resp  = 1'b0;
      mb.rdata = 32'h0;
      lb.rmask = 4'h0;
      repeat (3) @(negedge clk);
      chk("err_sticky", {31'h0, err}, 32'h1);
      chk("to_rmask", {28'h0, mb.rmask}, 32'h0);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
